// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multicycle datapath.
// Sequences fetch/decode/execute/writeback and counts retired instructions.
//
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   op                 opcode from instruction register (read in DECODE)
//   mem_ready          memory handshake, access completes when 1
//   zero               ALU zero flag for BRANCH
//   pcwrite..alusrca   single-bit datapath strobes/selects
//   alusrcb, aluop     ALU operand B select and operation class
//   pcsrc              next-PC source select
//   halted, illegal    in HALT / HALT reached via illegal opcode (sticky)
//   instr_count        saturating retired-instruction counter
//   state              current state encoding (debug)
module multicycle_ctrl #(
    parameter int OP_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [OP_W-1:0]  op,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             pcwrite,
    output logic             irwrite,
    output logic             iord,
    output logic             memwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsrc,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        HALT   = 4'd12
    } state_t;

    state_t cur;
    state_t nxt;
    state_t dec_nxt;

    // Only the low three bits are kept: anything reaching MEMADR
    // is lw or sw, so the upper bits are known to be zero.
    logic [2:0] op_q;
    logic [2:0] lo;
    logic       hi_ok;
    logic       illegal_op;
    logic       retire;

    assign lo         = op[2:0];
    assign hi_ok      = ((op >> 3) == '0);
    assign illegal_op = !hi_ok || (lo == 3'b110);
    assign retire     = (nxt == FETCH) && (cur != FETCH);
    assign state      = cur;

    // Opcode decode; items are mutually exclusive.
    always_comb begin
        dec_nxt = HALT;
        unique case (1'b1)
            hi_ok && lo == 3'b000: dec_nxt = EXEC;
            hi_ok && lo == 3'b001: dec_nxt = MEMADR;
            hi_ok && lo == 3'b010: dec_nxt = MEMADR;
            hi_ok && lo == 3'b011: dec_nxt = BRANCH;
            hi_ok && lo == 3'b100: dec_nxt = ADDIEX;
            hi_ok && lo == 3'b101: dec_nxt = JUMP;
            default:               dec_nxt = HALT;
        endcase
    end

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:  nxt = mem_ready ? DECODE : FETCH;
            DECODE: nxt = dec_nxt;
            MEMADR: nxt = (op_q == 3'b001) ? MEMRD : MEMWR;
            MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
            MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
            EXEC:   nxt = ALUWB;
            ADDIEX: nxt = ADDIWB;
            MEMWB:  nxt = FETCH;
            ALUWB:  nxt = FETCH;
            ADDIWB: nxt = FETCH;
            BRANCH: nxt = FETCH;
            JUMP:   nxt = FETCH;
            HALT:   nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        pcwrite  = 1'b0;
        irwrite  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        halted   = 1'b0;
        case (cur)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            DECODE: alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = mem_ready;
            end
            EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                pcwrite = zero;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur         <= FETCH;
            op_q        <= '0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            cur <= nxt;
            if (cur == DECODE) begin
                op_q <= lo;
            end
            // Halt opcode is legal, so it never sets the flag.
            if (cur == DECODE && illegal_op) begin
                illegal <= 1'b1;
            end
            if (retire && instr_count != '1) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of multicycle_ctrl state walk,
// strobes, stalls, halt/illegal, counter saturation and reset.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] op;
    logic       mem_ready;
    logic       zero;
    logic       pcwrite, irwrite, iord, memwrite;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       halted, illegal;
    logic [1:0] instr_count;
    logic [3:0] state;
    logic [14:0] ctl;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.OP_W(5), .CNT_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .op(op),
        .mem_ready(mem_ready), .zero(zero),
        .pcwrite(pcwrite), .irwrite(irwrite), .iord(iord),
        .memwrite(memwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .pcsrc(pcsrc), .halted(halted),
        .illegal(illegal), .instr_count(instr_count), .state(state)
    );

    assign ctl = {pcwrite, irwrite, iord, memwrite, regdst, memtoreg,
                  regwrite, alusrca, alusrcb, aluop, pcsrc, halted};

    // ctl layout: pcw irw iord memw regdst m2r regw srca | srcb aluop pcsrc | halted
    localparam logic [14:0] C_F1  = 15'b11000000_01_00_00_0;
    localparam logic [14:0] C_F0  = 15'b00000000_01_00_00_0;
    localparam logic [14:0] C_DEC = 15'b00000000_11_00_00_0;
    localparam logic [14:0] C_MA  = 15'b00000001_10_00_00_0;
    localparam logic [14:0] C_MRD = 15'b00100000_00_00_00_0;
    localparam logic [14:0] C_MWB = 15'b00000110_00_00_00_0;
    localparam logic [14:0] C_MW1 = 15'b00110000_00_00_00_0;
    localparam logic [14:0] C_MW0 = 15'b00100000_00_00_00_0;
    localparam logic [14:0] C_EX  = 15'b00000001_00_10_00_0;
    localparam logic [14:0] C_AWB = 15'b00001010_00_00_00_0;
    localparam logic [14:0] C_BR1 = 15'b10000001_00_01_01_0;
    localparam logic [14:0] C_BR0 = 15'b00000001_00_01_01_0;
    localparam logic [14:0] C_AIX = 15'b00000001_10_00_00_0;
    localparam logic [14:0] C_AIW = 15'b00000010_00_00_00_0;
    localparam logic [14:0] C_J   = 15'b10000000_00_00_10_0;
    localparam logic [14:0] C_H   = 15'b00000000_00_00_00_1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check current state and strobes, advance.
    task automatic cyc(input string tag, input logic mr, input logic z,
                       input logic [3:0] es, input logic [14:0] ec);
        mem_ready = mr;
        zero      = z;
        #1;
        check({tag, " st"}, 32'(state), 32'(es));
        check({tag, " ctl"}, 32'(ctl), 32'(ec));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst st", 32'(state), 32'd0);
        check("rst cnt", 32'(instr_count), 32'd0);
        check("rst ill", 32'(illegal), 32'd0);
    endtask

    task automatic jump_instr(input string tag);
        op = 5'b00101;
        cyc({tag, " f"}, 1'b1, 1'b0, 4'd0, C_F1);
        cyc({tag, " d"}, 1'b1, 1'b0, 4'd1, C_DEC);
        cyc({tag, " j"}, 1'b1, 1'b0, 4'd11, C_J);
    endtask

    initial begin
        reset_n   = 1'b0;
        op        = 5'b00000;
        mem_ready = 1'b1;
        zero      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("init st", 32'(state), 32'd0);
        check("init ctl", 32'(ctl), 32'(C_F1));
        check("init cnt", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1;
        do_reset();

        // lw, no stalls; op changed after DECODE must not matter
        op = 5'b00001;
        cyc("lw f", 1'b1, 1'b0, 4'd0, C_F1);
        cyc("lw d", 1'b1, 1'b0, 4'd1, C_DEC);
        op = 5'b00010;
        cyc("lw ma", 1'b1, 1'b0, 4'd2, C_MA);
        cyc("lw rd", 1'b1, 1'b0, 4'd3, C_MRD);
        cyc("lw wb", 1'b1, 1'b0, 4'd4, C_MWB);
        check("lw end", 32'(state), 32'd0);
        check("lw cnt", 32'(instr_count), 32'd1);

        // lw with 2 FETCH and 3 MEMRD stall cycles: 10 cycles total
        do_reset();
        op = 5'b00001;
        cyc("lws f0", 1'b0, 1'b0, 4'd0, C_F0);
        cyc("lws f1", 1'b0, 1'b0, 4'd0, C_F0);
        cyc("lws f2", 1'b1, 1'b0, 4'd0, C_F1);
        cyc("lws d", 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("lws ma", 1'b1, 1'b0, 4'd2, C_MA);
        for (int i = 0; i < 3; i++) begin
            cyc("lws rd0", 1'b0, 1'b0, 4'd3, C_MRD);
        end
        cyc("lws rd1", 1'b1, 1'b0, 4'd3, C_MRD);
        cyc("lws wb", 1'b1, 1'b0, 4'd4, C_MWB);
        check("lws end", 32'(state), 32'd0);
        check("lws cnt", 32'(instr_count), 32'd1);

        // beq taken then not taken
        do_reset();
        op = 5'b00011;
        cyc("beq1 f", 1'b1, 1'b0, 4'd0, C_F1);
        cyc("beq1 d", 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("beq1 br", 1'b1, 1'b1, 4'd8, C_BR1);
        cyc("beq0 f", 1'b1, 1'b0, 4'd0, C_F1);
        cyc("beq0 d", 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("beq0 br", 1'b1, 1'b0, 4'd8, C_BR0);
        check("beq cnt", 32'(instr_count), 32'd2);

        // R-type then addi
        do_reset();
        op = 5'b00000;
        cyc("r f", 1'b1, 1'b0, 4'd0, C_F1);
        cyc("r d", 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("r ex", 1'b1, 1'b0, 4'd6, C_EX);
        cyc("r wb", 1'b1, 1'b0, 4'd7, C_AWB);
        op = 5'b00100;
        cyc("ai f", 1'b1, 1'b0, 4'd0, C_F1);
        cyc("ai d", 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("ai ex", 1'b1, 1'b0, 4'd9, C_AIX);
        cyc("ai wb", 1'b1, 1'b0, 4'd10, C_AIW);
        check("rai cnt", 32'(instr_count), 32'd2);

        // sw with one MEMWR stall
        op = 5'b00010;
        cyc("sw f", 1'b1, 1'b0, 4'd0, C_F1);
        cyc("sw d", 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("sw ma", 1'b1, 1'b0, 4'd2, C_MA);
        cyc("sw w0", 1'b0, 1'b0, 4'd5, C_MW0);
        cyc("sw w1", 1'b1, 1'b0, 4'd5, C_MW1);
        check("sw end", 32'(state), 32'd0);
        check("sw cnt", 32'(instr_count), 32'd3);

        // counter saturation at 3 with CNT_W=2
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            jump_instr("jmp");
            check("sat cnt", 32'(instr_count), 32'(k > 3 ? 3 : k));
        end

        // halt opcode: no retire, not illegal, holds
        do_reset();
        jump_instr("hj");
        op = 5'b00111;
        cyc("h f", 1'b1, 1'b0, 4'd0, C_F1);
        cyc("h d", 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("h h0", 1'b1, 1'b0, 4'd12, C_H);
        cyc("h h1", 1'b1, 1'b0, 4'd12, C_H);
        check("h cnt", 32'(instr_count), 32'd1);
        check("h ill", 32'(illegal), 32'd0);

        // nonzero upper opcode bit is illegal
        do_reset();
        jump_instr("ij");
        op = 5'b01001;
        cyc("i f", 1'b1, 1'b0, 4'd0, C_F1);
        cyc("i d", 1'b1, 1'b0, 4'd1, C_DEC);
        check("i ill", 32'(illegal), 32'd1);
        cyc("i h", 1'b1, 1'b0, 4'd12, C_H);
        check("i cnt", 32'(instr_count), 32'd1);
        do_reset();

        // reserved opcode 110 is illegal
        op = 5'b00110;
        cyc("rv f", 1'b1, 1'b0, 4'd0, C_F1);
        cyc("rv d", 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("rv h", 1'b1, 1'b0, 4'd12, C_H);
        check("rv ill", 32'(illegal), 32'd1);
        check("rv cnt", 32'(instr_count), 32'd0);

        // reset while stalled in MEMWR: no memwrite, back to FETCH
        do_reset();
        jump_instr("mj");
        op = 5'b00010;
        cyc("mr f", 1'b1, 1'b0, 4'd0, C_F1);
        cyc("mr d", 1'b1, 1'b0, 4'd1, C_DEC);
        cyc("mr ma", 1'b1, 1'b0, 4'd2, C_MA);
        mem_ready = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("mr st", 32'(state), 32'd5);
        check("mr memw", 32'(memwrite), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("mr rst st", 32'(state), 32'd0);
        check("mr rst cnt", 32'(instr_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
